// File: rtl/mul32_seq_pkg.sv
// mul32_seq_pkg: shared types, sizes and partial-product placement for mul32_seq_ctrl
package mul32_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam int BYTE_W = 8;
   localparam int NUM_PP = 16;
   localparam int PROD_W = 64;
   // step k pairs byte k[3:2] of a with byte k[1:0] of b, so the product lands at 8*(i+j)
   function automatic logic [PROD_W-1:0] place_pp(input logic [2*BYTE_W-1:0] pp, input logic [3:0] k);
      return {{(PROD_W-2*BYTE_W){1'b0}}, pp} << (BYTE_W * (int'(k[3:2]) + int'(k[1:0])));
   endfunction
endpackage

// File: rtl/mul32_seq_ctrl_wallace.sv
// wallace: combinational 8x8 unsigned multiplier built from a carry-save reduction tree
// ports: a, b (8-bit operands) -> p (16-bit product)
module wallace (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      return {((x & y) | (x & z) | (y & z)) << 1, x ^ y ^ z};
   endfunction
   logic [15:0] r [8];
   logic [31:0] l1a, l1b, l2a, l2b, l3, l4;
   always_comb begin
      for (int i = 0; i < 8; i++) r[i] = {8'b0, b[i] ? a : 8'b0} << i;
      l1a = csa(r[0], r[1], r[2]);
      l1b = csa(r[3], r[4], r[5]);
      l2a = csa(l1a[15:0], l1a[31:16], l1b[15:0]);
      l2b = csa(l1b[31:16], r[6], r[7]);
      l3  = csa(l2a[15:0], l2a[31:16], l2b[15:0]);
      l4  = csa(l3[15:0], l3[31:16], l2b[31:16]);
      p   = l4[15:0] + l4[31:16];
   end
endmodule

// File: rtl/mul32_seq_ctrl.sv
// mul32_seq_ctrl: 32x32->64 unsigned multiply via sixteen byte products through one shared 8x8 multiplier
// ports: clk, rst (async, active-high); in_valid/in_ready/in_a/in_b operand handshake;
//        flush (sync abort); out_valid/out_ready/out_p result handshake; busy (RUN or DRAIN)
// REG_PP=1 registers each byte product before accumulation, adding a DRAIN cycle.
module mul32_seq_ctrl
   import mul32_seq_pkg::*;
#(
   parameter bit REG_PP = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_a,
   input  logic [31:0]       in_b,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_p,
   output logic              busy
);
   state_t state, state_nx;
   logic [31:0] a_q, b_q;
   logic [PROD_W-1:0] acc, add_val;
   logic [3:0] cnt, k_q;
   logic [2*BYTE_W-1:0] pp, pp_q;
   logic [BYTE_W-1:0] a_byte, b_byte;
   logic add_en;

   assign a_byte = a_q[cnt[3:2]*BYTE_W +: BYTE_W];
   assign b_byte = b_q[cnt[1:0]*BYTE_W +: BYTE_W];

   wallace u_mul (.a(a_byte), .b(b_byte), .p(pp));

   // registered mode adds the previous step's product, so the first RUN cycle adds nothing
   assign add_en  = REG_PP ? ((state == RUN && cnt != 4'd0) || state == DRAIN) : state == RUN;
   assign add_val = REG_PP ? place_pp(pp_q, k_q) : place_pp(pp, cnt);

   assign in_ready  = state == IDLE;
   assign busy      = state == RUN || state == DRAIN;
   assign out_valid = state == DONE;
   assign out_p     = acc;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? RUN : IDLE;
         RUN:     state_nx = cnt == 4'(NUM_PP - 1) ? (REG_PP ? DRAIN : DONE) : RUN;
         DRAIN:   state_nx = DONE;
         DONE:    state_nx = out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         acc  <= '0;
         cnt  <= '0;
         pp_q <= '0;
         k_q  <= '0;
      end else begin
         if (state == RUN) begin
            pp_q <= pp;
            k_q  <= cnt;
         end
         if (flush) begin
            acc <= '0;
            cnt <= '0;
         end else if (state == IDLE && in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
            acc <= '0;
            cnt <= '0;
         end else begin
            if (state == RUN) cnt <= cnt + 4'd1;
            if (add_en) acc <= acc + add_val;
         end
      end
endmodule
